// File: rtl/matrix_write_arbiter.sv
// Write-port arbiter for matrix_out: host/pattern round-robin sharing plus frame-memory clear.
// Define MATRIX_ARB_FIXED_PRIORITY_EN to make the host always win a tie.
module matrix_write_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned DEPTH       = 128,
  parameter logic [7:0]  CLEAR_VALUE = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  h_valid,
  output logic                  h_ready,
  input  logic [ADDR_WIDTH-1:0] h_address,
  input  logic [7:0]            h_data,
  input  logic                  p_valid,
  output logic                  p_ready,
  input  logic [ADDR_WIDTH-1:0] p_address,
  input  logic [7:0]            p_data,
  input  logic                  clear_req,
  output logic [ADDR_WIDTH-1:0] address_out,
  output logic [7:0]            data_out,
  output logic                  write_strobe_out,
  output logic                  busy,
  output logic                  err_oob
);

  localparam logic [0:0] StClear = 1'b0;
  localparam logic [0:0] StRun   = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] LastIdx    = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] DepthLimit = ADDR_WIDTH'(DEPTH);

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] index_q, index_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            data_q, data_d;
  logic                  strobe_q, strobe_d;
  logic                  err_q, err_d;

  logic                  grant_vld;
  logic                  grant_p;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [7:0]            sel_data;
  logic                  sel_oob;

`ifndef MATRIX_ARB_FIXED_PRIORITY_EN
  // Requester served by the most recent transfer; 1 = pattern generator.
  logic last_grant_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant_q <= 1'b1;
    end else if (grant_vld) begin
      last_grant_q <= grant_p;
    end
  end
`endif

  // Grant never depends on ready, and clear_req suppresses any grant in that cycle.
  always_comb begin
    grant_vld = 1'b0;
    grant_p   = 1'b0;
    if (state_q == StRun && !clear_req) begin
      if (h_valid && p_valid) begin
        grant_vld = 1'b1;
`ifdef MATRIX_ARB_FIXED_PRIORITY_EN
        grant_p   = 1'b0;
`else
        grant_p   = ~last_grant_q;
`endif
      end else if (h_valid) begin
        grant_vld = 1'b1;
        grant_p   = 1'b0;
      end else if (p_valid) begin
        grant_vld = 1'b1;
        grant_p   = 1'b1;
      end
    end
  end

  assign h_ready = grant_vld & ~grant_p;
  assign p_ready = grant_vld & grant_p;

  assign sel_addr = grant_p ? p_address : h_address;
  assign sel_data = grant_p ? p_data : h_data;
  assign sel_oob  = (sel_addr >= DepthLimit);

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    addr_d   = addr_q;
    data_d   = data_q;
    strobe_d = 1'b0;
    err_d    = err_q;
    if (state_q == StClear) begin
      if (clear_req) begin
        // Restart skips this cycle's write so the next strobe is address 0.
        index_d = '0;
        err_d   = 1'b0;
      end else begin
        addr_d   = index_q;
        data_d   = CLEAR_VALUE;
        strobe_d = 1'b1;
        if (index_q == LastIdx) begin
          state_d = StRun;
          index_d = '0;
        end else begin
          index_d = index_q + 1'b1;
        end
      end
    end else begin
      if (clear_req) begin
        state_d = StClear;
        index_d = '0;
        err_d   = 1'b0;
      end else if (grant_vld) begin
        if (sel_oob) begin
          err_d = 1'b1;
        end else begin
          addr_d   = sel_addr;
          data_d   = sel_data;
          strobe_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StClear;
      index_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
    end
  end

  assign address_out      = addr_q;
  assign data_out         = data_q;
  assign write_strobe_out = strobe_q;
  assign busy             = (state_q == StClear);
  assign err_oob          = err_q;

endmodule

// File: tb/tb_matrix_write_arbiter.sv
// Directed bench for matrix_write_arbiter: vector table for RUN-state arbitration plus
// hand sequences for clear, clear restart, tie interleave and mid-burst reset.
module tb_matrix_write_arbiter;

  logic       clk;
  logic       rst;
  logic       h_valid, h_ready, p_valid, p_ready;
  logic [8:0] h_address, p_address, address_out;
  logic [7:0] h_data, p_data, data_out;
  logic       clear_req, write_strobe_out, busy, err_oob;

  int total = 0;
  int bad   = 0;

  matrix_write_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .h_valid          (h_valid),
    .h_ready          (h_ready),
    .h_address        (h_address),
    .h_data           (h_data),
    .p_valid          (p_valid),
    .p_ready          (p_ready),
    .p_address        (p_address),
    .p_data           (p_data),
    .clear_req        (clear_req),
    .address_out      (address_out),
    .data_out         (data_out),
    .write_strobe_out (write_strobe_out),
    .busy             (busy),
    .err_oob          (err_oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  typedef struct {
    logic       hv;
    logic [8:0] ha;
    logic [7:0] hd;
    logic       pv;
    logic [8:0] pa;
    logic [7:0] pd;
    logic       hr;
    logic       pr;
    logic       stb;
    logic [8:0] addr;
    logic [7:0] data;
    logic       err;
  } vec_t;

  function automatic vec_t mk(input logic hv, input logic [8:0] ha, input logic [7:0] hd,
                              input logic pv, input logic [8:0] pa, input logic [7:0] pd,
                              input logic hr, input logic pr, input logic stb,
                              input logic [8:0] addr, input logic [7:0] data, input logic err);
    vec_t v;
    v.hv = hv; v.ha = ha; v.hd = hd; v.pv = pv; v.pa = pa; v.pd = pd;
    v.hr = hr; v.pr = pr; v.stb = stb; v.addr = addr; v.data = data; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic hv, input logic [8:0] ha, input logic [7:0] hd,
                       input logic pv, input logic [8:0] pa, input logic [7:0] pd,
                       input logic cr);
    h_valid = hv; h_address = ha; h_data = hd;
    p_valid = pv; p_address = pa; p_data = pd;
    clear_req = cr;
    #1;
  endtask

  // Called in the first CLEAR cycle; returns in the first RUN cycle.
  task automatic clear_watch(input string tag);
    int  nstrb, nbad, nbusy, nrdy;
    bit  done;
    nstrb = 0; nbad = 0; nbusy = 0; nrdy = 0; done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (busy) begin
        nbusy++;
        if (h_ready || p_ready) nrdy++;
      end
      if (write_strobe_out) begin
        if (address_out !== 9'(nstrb) || data_out !== 8'h00) nbad++;
        nstrb++;
      end
      if (!busy) done = 1;
      else tick();
    end
    chk({tag, "_strobes"}, nstrb, 128);
    chk({tag, "_addr_seq_errs"}, nbad, 0);
    chk({tag, "_busy_cycles"}, nbusy, 128);
    chk({tag, "_ready_in_clear"}, nrdy, 0);
  endtask

  vec_t      tbl[9];
  logic [8:0] exp_seq[8];
  logic [8:0] got_addr[$];
  logic [7:0] got_data[$];

  initial begin
    int hi, pi, both;
    logic hr, pr;

    // Arbitration vectors; run with last_grant == P on entry.
    tbl[0] = mk(0, 9'd0,   8'h00, 0, 9'd0,   8'h00, 0, 0, 0, 9'd8,   8'h88, 0);
    tbl[1] = mk(1, 9'd5,   8'hAB, 0, 9'd0,   8'h00, 1, 0, 1, 9'd5,   8'hAB, 0);
    tbl[2] = mk(0, 9'd0,   8'h00, 0, 9'd0,   8'h00, 0, 0, 0, 9'd5,   8'hAB, 0);
    tbl[3] = mk(0, 9'd0,   8'h00, 1, 9'd127, 8'h7F, 0, 1, 1, 9'd127, 8'h7F, 0);
    tbl[4] = mk(1, 9'd128, 8'hCC, 0, 9'd0,   8'h00, 1, 0, 0, 9'd127, 8'h7F, 1);
    tbl[5] = mk(0, 9'd0,   8'h00, 1, 9'd3,   8'h33, 0, 1, 1, 9'd3,   8'h33, 1);
    tbl[6] = mk(1, 9'd40,  8'h40, 1, 9'd41,  8'h41, 1, 0, 1, 9'd40,  8'h40, 1);
`ifdef MATRIX_ARB_FIXED_PRIORITY_EN
    tbl[7] = mk(1, 9'd42,  8'h42, 1, 9'd41,  8'h41, 1, 0, 1, 9'd42,  8'h42, 1);
    tbl[8] = mk(0, 9'd0,   8'h00, 0, 9'd0,   8'h00, 0, 0, 0, 9'd42,  8'h42, 1);
    exp_seq = '{9'd10, 9'd11, 9'd12, 9'd13, 9'd20, 9'd21, 9'd22, 9'd23};
`else
    tbl[7] = mk(1, 9'd42,  8'h42, 1, 9'd41,  8'h41, 0, 1, 1, 9'd41,  8'h41, 1);
    tbl[8] = mk(0, 9'd0,   8'h00, 0, 9'd0,   8'h00, 0, 0, 0, 9'd41,  8'h41, 1);
    exp_seq = '{9'd10, 9'd20, 9'd11, 9'd21, 9'd12, 9'd22, 9'd13, 9'd23};
`endif

    // Reset with both requesters pending: nothing may be accepted during the clear.
    rst = 1'b0;
    drive(1, 9'd7, 8'hEE, 1, 9'd8, 8'h88, 0);
    tick();
    tick();
    chk("rst_strobe", write_strobe_out, 0);
    chk("rst_addr", address_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_err", err_oob, 0);
    chk("rst_busy", busy, 1);
    chk("rst_h_ready", h_ready, 0);
    chk("rst_p_ready", p_ready, 0);
    rst = 1'b1;
    #1;
    clear_watch("clear0");

    // First tie after reset goes to H, then P follows.
    chk("first_tie_h_ready", h_ready, 1);
    chk("first_tie_p_ready", p_ready, 0);
    tick();
    chk("first_tie_addr", address_out, 9'd7);
    chk("first_tie_data", data_out, 8'hEE);
    drive(0, 9'd0, 8'h00, 1, 9'd8, 8'h88, 0);
    chk("p_after_h_ready", p_ready, 1);
    tick();
    chk("p_after_h_strobe", write_strobe_out, 1);
    chk("p_after_h_addr", address_out, 9'd8);

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].hv, tbl[i].ha, tbl[i].hd, tbl[i].pv, tbl[i].pa, tbl[i].pd, 0);
      chk($sformatf("vec%0d_h_ready", i), h_ready, tbl[i].hr);
      chk($sformatf("vec%0d_p_ready", i), p_ready, tbl[i].pr);
      tick();
      chk($sformatf("vec%0d_strobe", i), write_strobe_out, tbl[i].stb);
      chk($sformatf("vec%0d_addr", i), address_out, tbl[i].addr);
      chk($sformatf("vec%0d_data", i), data_out, tbl[i].data);
      chk($sformatf("vec%0d_err", i), err_oob, tbl[i].err);
      chk($sformatf("vec%0d_busy", i), busy, 0);
    end

    // Four-beat contention, both requesters holding until accepted.
    hi = 0; pi = 0; both = 0;
    for (int c = 0; c < 20 && !(hi == 4 && pi == 4); c++) begin
      drive(hi < 4, 9'(10 + hi), 8'(8'hA0 + hi), pi < 4, 9'(20 + pi), 8'(8'hB0 + pi), 0);
      hr = h_ready;
      pr = p_ready;
      if (hr && pr) both++;
      tick();
      if (hr) hi++;
      if (pr) pi++;
      if (write_strobe_out) begin
        got_addr.push_back(address_out);
        got_data.push_back(data_out);
      end
    end
    drive(0, 9'd0, 8'h00, 0, 9'd0, 8'h00, 0);
    chk("tie_both_ready", both, 0);
    chk("tie_count", got_addr.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < got_addr.size()) begin
        chk($sformatf("tie_addr%0d", k), got_addr[k], exp_seq[k]);
        chk($sformatf("tie_data%0d", k), got_data[k],
            (exp_seq[k] < 9'd20) ? 8'(8'hA0 + exp_seq[k] - 9'd10)
                                 : 8'(8'hB0 + exp_seq[k] - 9'd20));
      end
    end

    // Out-of-range write, then clear_req clears the error and blocks a pending P.
    drive(1, 9'd200, 8'h55, 0, 9'd0, 8'h00, 0);
    chk("oob_h_ready", h_ready, 1);
    tick();
    chk("oob_strobe", write_strobe_out, 0);
    chk("oob_addr_hold", address_out, 9'd23);
    chk("oob_err", err_oob, 1);
    drive(0, 9'd0, 8'h00, 1, 9'd9, 8'h99, 1);
    chk("clrreq_p_ready", p_ready, 0);
    tick();
    drive(0, 9'd0, 8'h00, 1, 9'd9, 8'h99, 0);
    chk("clrreq_err", err_oob, 0);
    chk("clrreq_busy", busy, 1);
    chk("clrreq_strobe", write_strobe_out, 0);
    clear_watch("clear1");
    chk("post_clear_p_ready", p_ready, 1);
    tick();
    chk("post_clear_p_addr", address_out, 9'd9);
    chk("post_clear_p_strobe", write_strobe_out, 1);
    drive(0, 9'd0, 8'h00, 0, 9'd0, 8'h00, 0);

    // Restart a clear partway through.
    drive(0, 9'd0, 8'h00, 0, 9'd0, 8'h00, 1);
    tick();
    drive(0, 9'd0, 8'h00, 0, 9'd0, 8'h00, 0);
    repeat (60) tick();
    chk("mid_clear_strobe", write_strobe_out, 1);
    chk("mid_clear_addr", address_out, 9'd59);
    drive(0, 9'd0, 8'h00, 0, 9'd0, 8'h00, 1);
    tick();
    drive(0, 9'd0, 8'h00, 0, 9'd0, 8'h00, 0);
    chk("restart_strobe", write_strobe_out, 0);
    chk("restart_busy", busy, 1);
    clear_watch("clear2");

    // Host burst interrupted by reset.
    drive(1, 9'd300, 8'h11, 0, 9'd0, 8'h00, 0);
    tick();
    chk("pre_rst_err", err_oob, 1);
    for (int k = 0; k < 5; k++) begin
      drive(1, 9'(50 + k), 8'(8'h50 + k), 0, 9'd0, 8'h00, 0);
      tick();
    end
    chk("burst_addr", address_out, 9'd54);
    chk("burst_data", data_out, 8'h54);
    rst = 1'b0;
    drive(1, 9'd55, 8'h55, 1, 9'd98, 8'h98, 0);
    tick();
    chk("midrst_strobe", write_strobe_out, 0);
    chk("midrst_addr", address_out, 0);
    chk("midrst_data", data_out, 0);
    chk("midrst_err", err_oob, 0);
    chk("midrst_busy", busy, 1);
    chk("midrst_h_ready", h_ready, 0);
    chk("midrst_p_ready", p_ready, 0);
    rst = 1'b1;
    drive(1, 9'd99, 8'h99, 1, 9'd98, 8'h98, 0);
    clear_watch("clear3");
    chk("after_rst_h_ready", h_ready, 1);
    chk("after_rst_p_ready", p_ready, 0);
    tick();
    chk("after_rst_h_addr", address_out, 9'd99);
    drive(0, 9'd0, 8'h00, 1, 9'd98, 8'h98, 0);
    chk("after_rst_p_ready2", p_ready, 1);
    tick();
    chk("after_rst_p_addr", address_out, 9'd98);
    drive(0, 9'd0, 8'h00, 0, 9'd0, 8'h00, 0);
    tick();
    chk("final_idle_strobe", write_strobe_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
